// File: rtl/demux16_deser.sv
// -----------------------------------------------------------------------------
// demux16_deser
//   1-to-16 registered demultiplexer / deserializer. One data bit is accepted
//   per valid cycle. Each bit is written either at an auto-incrementing pointer
//   or at an explicit select position. When every position holds a bit, the
//   word is published on out and offered with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in         data bit
//   in_valid   bit on in is presented this cycle
//   in_ready   block accepts a bit this cycle (decoded from state only)
//   sel        target bit position when sel_en = 1
//   sel_en     1 = addressed write at sel, 0 = auto write at ptr
//   flush      discard the partial word (ignored while holding a word)
//   out        assembled word
//   out_valid  out holds a complete word
//   out_ready  consumer takes the word
//   ptr        current auto pointer
//   wr_mask    positions written in the current partial word
// -----------------------------------------------------------------------------
module demux16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_en,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] ptr,
  output logic [WIDTH-1:0] wr_mask
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   wr_mask_q, wr_mask_d;

  logic               accept;
  logic [SEL_W-1:0]   tgt;
  logic [WIDTH-1:0]   tgt_onehot;
  logic [WIDTH-1:0]   merged;
  logic               complete;

  // in_ready depends on registered state only, so a consumer's out_ready
  // never reaches the producer combinationally.
  assign in_ready = (state_q == FILL);

  assign accept     = in_valid && in_ready && !flush;
  assign tgt        = sel_en ? sel : ptr_q;
  assign tgt_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << tgt;
  // Shadow word with the incoming bit written at tgt (overwrite on duplicates).
  assign merged     = (shadow_q & ~tgt_onehot) | (in ? tgt_onehot : '0);
  // Completion is judged on the mask alone, so mixed auto/addressed writes and
  // pointer wrap onto written positions behave consistently.
  assign complete   = accept && (&(wr_mask_q | tgt_onehot));

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a value unassigned;
    // a missing default here would infer a latch.
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    wr_mask_d   = wr_mask_q;

    unique case (state_q)
      FILL: begin
        if (flush) begin
          // Flush drops the partial word; a bit presented alongside is lost.
          wr_mask_d = '0;
          ptr_d     = '0;
        end else if (accept) begin
          shadow_d = merged;
          if (complete) begin
            out_d       = merged;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            wr_mask_d   = '0;
            ptr_d       = '0;
          end else begin
            wr_mask_d = wr_mask_q | tgt_onehot;
            if (!sel_en) ptr_d = ptr_q + 1'b1;  // wraps 15 -> 0
          end
        end
      end
      HOLD: begin
        // out keeps its value after the handshake; only valid drops. The
        // return to FILL costs one bubble cycle before the next accept.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= FILL;
      // NOTE: the shadow word is reset as well, so the partial word never
      // carries bits from before reset into a published word.
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      wr_mask_q   <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      wr_mask_q   <= wr_mask_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ptr       = ptr_q;
  assign wr_mask   = wr_mask_q;

endmodule

// File: tb/tb_demux16_deser.sv
// -----------------------------------------------------------------------------
// tb_demux16_deser
//   Directed bench for demux16_deser. Inputs change 1 ns after a rising edge
//   and outputs are sampled at that same point, i.e. after the edge settles.
// -----------------------------------------------------------------------------
module tb_demux16_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic        sel_en;
  logic        flush;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ptr;
  logic [15:0] wr_mask;

  int checks = 0;
  int errors = 0;

  demux16_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .sel_en    (sel_en),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr),
    .wr_mask   (wr_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; afterwards outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Feed 16 auto-mode bits LSB first, back-to-back.
  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      in       = w[i];
      in_valid = 1'b1;
      sel_en   = 1'b0;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_addr(input logic b, input logic [3:0] s);
    in       = b;
    sel      = s;
    sel_en   = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sel_en   = 1'b0;
  endtask

  // Take the held word with a one-cycle out_ready pulse.
  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},       32'(out),       32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ptr"},       32'(ptr),       32'd0);
    check({tag, "_wr_mask"},   32'(wr_mask),   32'h0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b0; in = 1'b0; in_valid = 1'b0; sel = '0; sel_en = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    // ---- reset state ----
    do_reset();
    check_reset_state("rst0");

    // ---- auto mode 0xA5C3, out_ready held high ----
    out_ready = 1'b1;
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      in = w[i]; in_valid = 1'b1; sel_en = 1'b0;
      step();
      if (i == 14) begin
        check("auto_mask15", 32'(wr_mask),   32'h7FFF);
        check("auto_ptr15",  32'(ptr),       32'd15);
        check("auto_nv15",   32'(out_valid), 32'd0);
      end
    end
    check("auto_valid",  32'(out_valid), 32'd1);
    check("auto_out",    32'(out),       32'hA5C3);
    check("auto_busy",   32'(in_ready),  32'd0);
    check("auto_ptr0",   32'(ptr),       32'd0);
    check("auto_mask0",  32'(wr_mask),   32'h0);
    // in_valid still high in HOLD: that bit must be ignored.
    in = 1'b1;
    step();
    in_valid = 1'b0;
    check("auto_hs_valid", 32'(out_valid), 32'd0);
    check("auto_hs_ready", 32'(in_ready),  32'd1);
    check("auto_keep_out", 32'(out),       32'hA5C3);
    check("auto_hold_ign_mask", 32'(wr_mask), 32'h0);
    check("auto_hold_ign_ptr",  32'(ptr),     32'd0);

    // ---- backpressure 0x1234 ----
    out_ready = 1'b0;
    send_word(16'h1234);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_out",   32'(out),       32'h1234);
    for (int c = 0; c < 5; c++) begin
      in = c[0]; in_valid = c[1] | c[0]; sel = 4'(c); sel_en = c[1];
      step();
      check("bp_hold_out",   32'(out),       32'h1234);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    check("bp_ign_mask", 32'(wr_mask), 32'h0);
    check("bp_ign_ptr",  32'(ptr),     32'd0);
    sel_en = 1'b0;
    drain("bp");
    out_ready = 1'b0;
    send_word(16'h00F0);
    check("bp_next_out",   32'(out),       32'h00F0);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    drain("bp_next");

    // ---- addressed mode 0x8001, sel 15 -> 0 ----
    out_ready = 1'b0;
    w = 16'h8001;
    for (int s = 15; s >= 0; s--) begin
      send_addr(w[s], 4'(s));
      check("addr_ptr", 32'(ptr), 32'd0);
      if (s == 1) check("addr_nv", 32'(out_valid), 32'd0);
    end
    check("addr_valid", 32'(out_valid), 32'd1);
    check("addr_out",   32'(out),       32'h8001);
    drain("addr");

    // ---- duplicate / overwrite ----
    out_ready = 1'b0;
    send_addr(1'b1, 4'd3);
    check("dup_mask1", 32'(wr_mask), 32'h0008);
    send_addr(1'b0, 4'd3);
    check("dup_mask2", 32'(wr_mask),   32'h0008);
    check("dup_nv2",   32'(out_valid), 32'd0);
    check("dup_ptr",   32'(ptr),       32'd0);
    for (int s = 0; s < 16; s++) begin
      if (s != 3) begin
        send_addr(1'b0, 4'(s));
        if (s == 14) check("dup_nv15", 32'(out_valid), 32'd0);
      end
    end
    check("dup_valid", 32'(out_valid), 32'd1);
    check("dup_out",   32'(out),       32'h0000);
    drain("dup");

    // ---- flush ----
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in = 1'b1; in_valid = 1'b1; sel_en = 1'b0;
      step();
    end
    check("fl_ptr7",  32'(ptr),     32'd7);
    check("fl_mask7", 32'(wr_mask), 32'h007F);
    in = 1'b1; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_mask", 32'(wr_mask),   32'h0);
    check("fl_ptr",  32'(ptr),       32'd0);
    check("fl_nv",   32'(out_valid), 32'd0);
    send_word(16'hFFFF);
    check("fl_out",   32'(out),       32'hFFFF);
    check("fl_valid", 32'(out_valid), 32'd1);
    // Flush while holding is ignored.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_hold_valid", 32'(out_valid), 32'd1);
    check("fl_hold_out",   32'(out),       32'hFFFF);
    drain("fl");

    // ---- reset mid-word ----
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in = 1'b1; in_valid = 1'b1; sel_en = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("rm_ptr9", 32'(ptr), 32'd9);
    do_reset();
    check_reset_state("rst_mid");
    send_word(16'h5A5A);
    check("rm_out",   32'(out),       32'h5A5A);
    check("rm_valid", 32'(out_valid), 32'd1);

    // ---- reset during HOLD ----
    step();
    check("rh_holding", 32'(out_valid), 32'd1);
    do_reset();
    check_reset_state("rst_hold");
    send_word(16'h0F0F);
    check("rh_out",   32'(out),       32'h0F0F);
    check("rh_valid", 32'(out_valid), 32'd1);
    drain("rh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
